// File: rtl/level_meter_pkg.sv
// level_meter_pkg: constants and FSM state encoding shared by the level meter.
//   SMAG_MAX : full-scale scaled magnitude (a clipping sample)
//   MAG_SAT  : magnitude saturation limit before scaling
//   state_e  : meter FSM states
package level_meter_pkg;

    localparam int unsigned SMAG_MAX = 255;
    localparam int unsigned MAG_SAT  = 2047;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHold  = 2'd1,
        StDecay = 2'd2
    } state_e;

endpackage

// File: rtl/level_meter_abs_scale.sv
// abs_scale: combinational magnitude of an offset-binary sample.
// Computes |sample - MID|, saturates it to MAG_SAT, then scales it to 8 bits (>> 3).
//   sample_i : ADC code, unsigned offset-binary
//   smag_o   : scaled magnitude, 0..255
module abs_scale
    import level_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned MID      = 2048
) (
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [7:0]          smag_o
);

    logic [31:0] samp_u;
    logic [31:0] mag;
    logic [10:0] mag_sat;

    always_comb begin
        samp_u  = 32'(sample_i);
        mag     = (samp_u >= MID) ? (samp_u - MID) : (MID - samp_u);
        // Code 0 gives MID (2048 for 12 bits), one past the positive range.
        mag_sat = (mag > MAG_SAT) ? 11'(MAG_SAT) : mag[10:0];
        smag_o  = 8'(mag_sat >> 3);
    end

endmodule

// File: rtl/level_meter.sv
// level_meter: frame-synchronous VU meter with peak hold and linear decay.
// Tracks the peak scaled magnitude of valid samples in each display frame. On every
// frame tick (v_sync going active), it updates the displayed level and the clip flag,
// so both stay constant for the whole of the next frame.
//   clk          : pixel clock
//   reset        : asynchronous, active-high
//   sample_valid : qualifies sample, one sample per asserted cycle
//   sample       : ADC code, unsigned offset-binary
//   v_sync       : vertical sync, active level given by V_POL
//   level        : VU level, 0..255
//   clip         : previous frame contained a full-scale sample
module level_meter
    import level_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = 12,
    parameter int unsigned MID         = 2048,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned DECAY_STEP  = 2,
    parameter bit          V_POL       = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                v_sync,
    output logic [7:0]          level,
    output logic                clip
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;

    logic [7:0]        smag;
    logic              tick;

    logic              vs_prev_q, vs_prev_d;
    logic [7:0]        frame_peak_q, frame_peak_d;
    logic [7:0]        level_q, level_d;
    logic              clip_q, clip_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    state_e            state_q, state_d;

    abs_scale #(
        .SAMPLE_W(SAMPLE_W),
        .MID     (MID)
    ) u_abs_scale (
        .sample_i(sample),
        .smag_o  (smag)
    );

    // A tick fires only on the inactive-to-active edge; holding v_sync active does nothing.
    assign tick = (v_sync == V_POL) && (vs_prev_q != V_POL);

    always_comb begin
        vs_prev_d    = v_sync;
        frame_peak_d = frame_peak_q;
        level_d      = level_q;
        clip_d       = clip_q;
        hold_cnt_d   = hold_cnt_q;
        state_d      = state_q;

        if (tick) begin
            // A sample that arrives on the tick cycle opens the new frame.
            frame_peak_d = sample_valid ? smag : 8'd0;
            clip_d       = (frame_peak_q == 8'(SMAG_MAX));

            if ((frame_peak_q >= level_q) && (frame_peak_q != 8'd0)) begin
                level_d    = frame_peak_q;
                hold_cnt_d = HOLD_W'(HOLD_FRAMES - 1);
                state_d    = StHold;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        level_d = 8'd0;
                    end
                    StHold: begin
                        if (hold_cnt_q != '0) begin
                            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                        end else begin
                            state_d = StDecay;
                        end
                    end
                    StDecay: begin
                        if (32'(level_q) > DECAY_STEP) begin
                            level_d = level_q - 8'(DECAY_STEP);
                        end else begin
                            level_d = 8'd0;
                            state_d = StIdle;
                        end
                    end
                    default: begin
                        level_d = 8'd0;
                        state_d = StIdle;
                    end
                endcase
            end
        end else if (sample_valid && (smag > frame_peak_q)) begin
            frame_peak_d = smag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev_q    <= ~V_POL;
            frame_peak_q <= 8'd0;
            level_q      <= 8'd0;
            clip_q       <= 1'b0;
            hold_cnt_q   <= '0;
            state_q      <= StIdle;
        end else begin
            vs_prev_q    <= vs_prev_d;
            frame_peak_q <= frame_peak_d;
            level_q      <= level_d;
            clip_q       <= clip_d;
            hold_cnt_q   <= hold_cnt_d;
            state_q      <= state_d;
        end
    end

    assign level = level_q;
    assign clip  = clip_q;

endmodule

// File: doc/level_meter.md
LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SAMPLE_W, 12, ADC sample width (unsigned offset-binary).
- MID, 2048, midscale (zero-signal) code.
- HOLD_FRAMES, 30, frames the peak is held before decay.
- DECAY_STEP, 2, level decrement per frame while decaying.
- V_POL, 0, v_sync polarity (0: active low); matches the display stage.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock (pixel clock domain).
- reset, in, 1, asynchronous, active-high reset.
- sample_valid, in, 1, sample qualifier; one sample per asserted cycle.
- sample, in, SAMPLE_W, audio ADC code.
- v_sync, in, 1, vertical sync from the display stage.
- level, out, 8, VU level fed to the display stage's data input.
- clip, out, 1, frame contained a full-scale sample.

Function
REQ-003 The block SHALL compute mag = |sample - MID| and saturate it to 2047.
REQ-004 The block SHALL compute smag = mag >> 3 (0..255) for each valid sample.
REQ-005 The block SHALL keep frame_peak = max(smag) over all valid samples since the last frame tick.
REQ-006 The block SHALL generate a frame tick on the cycle where registered v_sync changes from inactive (!V_POL) to active (V_POL), using a single registered previous-value compare.
REQ-007 On a tick, the block SHALL load frame_peak with smag when sample_valid is high that cycle, and with 0 otherwise. That sample counts toward the new frame only.
REQ-008 The FSM SHALL have three states: IDLE, HOLD, DECAY. All updates SHALL occur only on tick cycles, and outputs SHALL change on the following clock edge (latency 1).
REQ-009 On a tick with frame_peak >= level and frame_peak != 0, the block SHALL set level = frame_peak, set hold_cnt = HOLD_FRAMES - 1, and go to HOLD. This applies from any state.
REQ-010 In HOLD, on a tick without a new peak:
- if hold_cnt != 0, the block SHALL decrement hold_cnt;
- if hold_cnt == 0, the block SHALL go to DECAY.
REQ-011 In DECAY, on a tick without a new peak, the block SHALL set level = level - DECAY_STEP, saturating at 0. When the result is 0 it SHALL go to IDLE.
REQ-012 In IDLE with frame_peak == 0, level SHALL remain 0.
REQ-013 On each tick, clip SHALL be set to 1 if frame_peak == 255 and cleared to 0 otherwise, and held for the whole next frame.
REQ-014 level and clip SHALL be constant between ticks, so there is no mid-frame tearing.
REQ-015 Samples arriving while v_sync is held active SHALL accumulate normally; only the edge produces a tick.

Reset
REQ-016 Reset SHALL asynchronously clear the following, and the first tick after reset release SHALL be detected normally:
- level = 0, clip = 0;
- state = IDLE, hold_cnt = 0, frame_peak = 0;
- previous v_sync register = !V_POL.
REQ-017 Reset asserted mid-HOLD or mid-DECAY SHALL abandon the sequence with no residual hold.

Structure
REQ-018 The FSM state encoding and the constants SMAG_MAX = 255 and MAG_SAT = 2047 SHALL live in the shared project package.
REQ-019 The block SHALL contain one sub-module, abs_scale, which combinationally computes smag from sample and MID. Everything else SHALL be flat, using the team's _ff/_nxt two-process style.

Verification
REQ-020 Scenario: sample = 2048 continuously over 3 ticks -> level = 0, clip = 0, state IDLE throughout.
REQ-021 Scenario: one valid sample 2048 + 800 in a frame, then silence -> after the next tick level = 100. It holds 100 for 30 ticks, then goes 98, 96, ... and reaches 0 after 50 decay ticks, then IDLE.
REQ-022 Scenario: sample = 0 -> mag saturates to 2047, smag = 255 -> after the tick level = 255 and clip = 1. The next silent frame's tick gives clip = 0 while level is held at 255.
REQ-023 Scenario: during decay at level 60, a frame with peak 80 -> level = 80 and HOLD restarts with a full 30-frame hold. A frame with peak 40 instead -> decay continues to 58.
REQ-024 Scenario: sample_valid with smag 200 on the exact tick cycle -> it is excluded from the closing frame and appears in level at the following tick.
REQ-025 Scenario: reset asserted in HOLD at level 150 -> level = 0 and clip = 0 immediately (asynchronous). After release, silence keeps level at 0.
